// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: slice index math, configuration check, stage control record.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package adder_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;

  // Per-stage control bits travelling alongside each partial sum.
  typedef struct packed {
    logic vld;
    logic cy;
  } stage_ctl_t;

  // Lowest bit index of carry slice k when each slice is sw bits wide.
  function automatic int slice_lo(input int k, input int sw);
    return k * sw;
  endfunction

  // Legal geometry: at least one stage, no more stages than bits, equal slices.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One SW-bit carry slice: sum and carry-out of two slices plus carry-in.
// Latency: combinational.
// Backpressure: none; purely combinational.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout
);

  // Widen by one bit so the slice carry-out falls out of the top.
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder, carry chain cut into STAGES slices; optional signed overflow (PIPELINED_ADDER_OVF_EN).
// Latency: STAGES cycles from accept to out_valid, one result per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready; bubbles are kept, not collapsed.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
  end

  // Index k is the boundary in front of stage k; index STAGES is the output register.
  stage_ctl_t       w_ctl [STAGES+1];
  logic [WIDTH-1:0] w_sum [STAGES+1];
  // Operands still to be consumed, already shifted so the next slice sits at bit 0.
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic             w_adv;

`ifdef PIPELINED_ADDER_OVF_EN
  // Operand sign bits ride along so the last stage can judge signed overflow.
  logic             w_sa  [STAGES+1];
  logic             w_sb  [STAGES+1];
  assign w_sa[0] = a[WIDTH-1];
  assign w_sb[0] = b[WIDTH-1];
`endif

  assign w_ctl[0] = '{vld: in_valid, cy: cin};
  assign w_sum[0] = '0;
  assign w_a[0]   = a;
  assign w_b[0]   = b;

  // The whole pipe moves together; it only stalls when a finished result is refused.
  assign w_adv    = !w_ctl[STAGES].vld || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_sum_nxt;
    stage_ctl_t       r_ctl;
    logic [WIDTH-1:0] r_sum;

    adder_slice #(.SW(SW)) u_slice (
      .i_a    (w_a[k][SW-1:0]),
      .i_b    (w_b[k][SW-1:0]),
      .i_cin  (w_ctl[k].cy),
      .o_sum  (w_slice_sum),
      .o_cout (w_slice_cout)
    );

    // Drop the freshly resolved slice into place above the lower result slices.
    always_comb begin
      w_sum_nxt = w_sum[k];
      w_sum_nxt[slice_lo(k, SW) +: SW] = w_slice_sum;
    end

    // Valid shifts on every advance; data only loads for real entries so the output holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ctl <= '0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_ctl.vld <= w_ctl[k].vld;
        if (w_ctl[k].vld) begin
          r_ctl.cy <= w_slice_cout;
          r_sum    <= w_sum_nxt;
        end
      end
    end

    assign w_ctl[k+1] = r_ctl;
    assign w_sum[k+1] = r_sum;

    // The last stage has no operands left to forward.
    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      // Forward the unconsumed upper slices, shifted down one slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_ctl[k].vld) begin
          r_a <= w_a[k] >> SW;
          r_b <= w_b[k] >> SW;
        end
      end

      assign w_a[k+1] = r_a;
      assign w_b[k+1] = r_b;
    end

`ifdef PIPELINED_ADDER_OVF_EN
    logic r_sa;
    logic r_sb;

    // Carry the operand sign bits in lockstep with the partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sa <= 1'b0;
        r_sb <= 1'b0;
      end else if (w_adv && w_ctl[k].vld) begin
        r_sa <= w_sa[k];
        r_sb <= w_sb[k];
      end
    end

    assign w_sa[k+1] = r_sa;
    assign w_sb[k+1] = r_sb;
`endif
  end

  assign out_valid = w_ctl[STAGES].vld;
  assign sum       = w_sum[STAGES];
  assign cout      = w_ctl[STAGES].cy;

`ifdef PIPELINED_ADDER_OVF_EN
  // Like-signed operands producing an opposite-signed sum; all-zero registers give 0 after reset.
  assign ovf = (w_sa[STAGES] == w_sb[STAGES]) && (sum[WIDTH-1] != w_sa[STAGES]);
`endif

endmodule
